// File: rtl/hs_seq_pkg.sv
// rtl/hs_seq_pkg.sv - shared types and cycle offsets for the handshake sequencer
package hs_seq_pkg;

  typedef enum logic [2:0] {IDLE, C0, C1, C2, C3, DONE} hs_state_t;

  localparam int A_OFS    = 2;
  localparam int B_OFS    = 1;
  localparam int STOP_OFS = 3;
  localparam int LAST_CYC = 3;

  typedef struct packed {
    logic start;
    logic a;
    logic b;
    logic stop;
    logic busy;
    logic done;
  } hs_out_t;

  // Cycle index of a transaction state, -1 outside C0..C3.
  function automatic int cyc_of(input hs_state_t s);
    case (s)
      C0:      return 0;
      C1:      return 1;
      C2:      return 2;
      C3:      return 3;
      default: return -1;
    endcase
  endfunction

endpackage

// File: rtl/hs_seq_ctrl_if.sv
// rtl/hs_seq_ctrl_if.sv - request and handshake signal bundle for the sequencer
interface hs_seq_ctrl_if #(parameter int CNT_W = 8);

  logic             req;
  logic             mode;
  logic             inject_err;
  logic             start;
  logic             a;
  logic             b;
  logic             stop;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] txn_count;

  modport master (
    output req, mode, inject_err,
    input  start, a, b, stop, busy, done, txn_count
  );

  modport slave (
    input  req, mode, inject_err,
    output start, a, b, stop, busy, done, txn_count
  );

endinterface

// File: rtl/hs_txn_counter.sv
// rtl/hs_txn_counter.sv - wrapping completed-transaction counter with increment enable
module hs_txn_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hs_seq_ctrl.sv
// rtl/hs_seq_ctrl.sv - drives one start/a/b/stop transaction per accepted request
module hs_seq_ctrl
  import hs_seq_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int START_LEN = 1
) (
  input  logic          clk,
  input  logic          rst,
  hs_seq_ctrl_if.slave  bus
);

  hs_state_t        r_state;
  hs_state_t        w_state_nxt;
  logic             r_mode;
  logic             r_err;
  logic             w_accept;
  logic             w_mode_nxt;
  logic             w_err_nxt;
  hs_out_t          r_out;
  hs_out_t          w_out_nxt;
  int               w_cyc;
  logic [CNT_W-1:0] w_count;

  assign w_accept   = (r_state == IDLE) && bus.req;
  assign w_mode_nxt = w_accept ? bus.mode       : r_mode;
  assign w_err_nxt  = w_accept ? bus.inject_err : r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_mode  <= 1'b0;
      r_err   <= 1'b0;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
      r_err   <= w_err_nxt;
      r_out   <= w_out_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.req) w_state_nxt = C0;
      C0:      w_state_nxt = C1;
      C1:      w_state_nxt = C2;
      C2:      w_state_nxt = C3;
      C3:      w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Decoding the next state lets every output be a flop yet line up with its cycle.
  always_comb begin
    w_out_nxt       = '0;
    w_cyc           = cyc_of(w_state_nxt);
    w_out_nxt.busy  = (w_cyc >= 0) && (w_cyc <= LAST_CYC);
    w_out_nxt.done  = (w_state_nxt == DONE);
    w_out_nxt.start = (w_cyc >= 0) && (w_cyc < START_LEN);
    w_out_nxt.a     = (w_cyc == A_OFS) && !w_mode_nxt && !w_err_nxt;
    w_out_nxt.b     = (w_cyc == B_OFS) && w_mode_nxt;
    w_out_nxt.stop  = (w_cyc == STOP_OFS) && w_mode_nxt && !w_err_nxt;
  end

  hs_txn_counter #(.W(CNT_W)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_out_nxt.done),
    .o_count (w_count)
  );

  assign bus.start     = r_out.start;
  assign bus.a         = r_out.a;
  assign bus.b         = r_out.b;
  assign bus.stop      = r_out.stop;
  assign bus.busy      = r_out.busy;
  assign bus.done      = r_out.done;
  assign bus.txn_count = w_count;

endmodule
